// File: rtl/turn_sequencer_pkg.sv
// Shared game definitions: phase/mode codes, default phase lengths and
// small player-rotation helpers used by the sequencer and the tick generator.
package turn_sequencer_pkg;

  localparam logic [2:0] MODE_IDLE   = 3'b000;
  localparam logic [2:0] MODE_SELECT = 3'b001;
  localparam logic [2:0] MODE_REVEAL = 3'b010;
  localparam logic [2:0] MODE_MOVE   = 3'b011;
  localparam logic [2:0] MODE_CHECK  = 3'b100;
  localparam logic [2:0] MODE_WIN    = 3'b101;

  localparam int REVEAL_TICKS_DEF = 3;
  localparam int WIN_TICKS_DEF    = 8;
  localparam int TICK_CNT_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = MODE_IDLE,
    ST_SELECT = MODE_SELECT,
    ST_REVEAL = MODE_REVEAL,
    ST_MOVE   = MODE_MOVE,
    ST_CHECK  = MODE_CHECK,
    ST_WIN    = MODE_WIN
  } state_e;

  // Player counts below two make no sense for a game, so they play as two.
  function automatic logic [1:0] norm_players(input logic [1:0] np);
    return (np < 2'd2) ? 2'd2 : np;
  endfunction

  function automatic logic [1:0] next_player(input logic [1:0] cur, input logic [1:0] np);
    return (cur == np - 2'd1) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/turn_sequencer_tick_counter.sv
// Tick counter shared by the timed phases: cleared on phase entry, counts
// enabled ticks and flags the tick that reaches the terminal count.
module tick_counter
  import turn_sequencer_pkg::*;
#(
  parameter int W = TICK_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         tick_i,
  input  logic [W-1:0] target_i,
  output logic         done_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;

  // done fires on the counted tick itself so the phase leaves at that edge
  assign done_o = en_i && tick_i && (cnt_q == target_i - ONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i || done_o) begin
      cnt_q <= '0;
    end else if (en_i && tick_i) begin
      cnt_q <= cnt_q + ONE;
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Turn sequencer for the tile game: walks SELECT/REVEAL/CHECK/MOVE per turn,
// rotates players, counts completed turns and holds WIN for a timed display.
module turn_sequencer
  import turn_sequencer_pkg::*;
#(
  parameter int N_TILE_BITS  = 4,
  parameter int REVEAL_TICKS = REVEAL_TICKS_DEF,
  parameter int WIN_TICKS    = WIN_TICKS_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tick_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [1:0]             num_players_i,
  input  logic                   pick_valid_i,
  input  logic [N_TILE_BITS-1:0] pick_idx_i,
  input  logic                   match_i,
  input  logic                   move_done_i,
  input  logic                   at_goal_i,
  output logic [2:0]             mode_o,
  output logic [1:0]             player_o,
  output logic [N_TILE_BITS-1:0] tile_sel_o,
  output logic                   move_req_o,
  output logic                   win_o,
  output logic [7:0]             turn_cnt_o
);

  state_e                 state_q, state_d;
  logic [1:0]             player_q, player_d;
  logic [1:0]             np_q, np_d;
  logic [N_TILE_BITS-1:0] tile_q, tile_d;
  logic [7:0]             turn_q, turn_d;
  logic                   move_req_q, win_q, entry_q;

  logic                   tc_clr, tc_en, tc_done;
  logic [TICK_CNT_W-1:0]  tc_target;

  assign tc_target = (state_q == ST_WIN) ? TICK_CNT_W'(WIN_TICKS) : TICK_CNT_W'(REVEAL_TICKS);
  // A tick landing on the first cycle of a timed phase belongs to the previous phase
  assign tc_en     = ((state_q == ST_REVEAL) || (state_q == ST_WIN)) && !entry_q;

  tick_counter #(.W(TICK_CNT_W)) u_tick_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (tc_clr),
    .en_i     (tc_en),
    .tick_i   (tick_i),
    .target_i (tc_target),
    .done_o   (tc_done)
  );

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    np_d     = np_q;
    tile_d   = tile_q;
    turn_d   = turn_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) begin
          state_d  = ST_SELECT;
          player_d = 2'd0;
          turn_d   = 8'd0;
          np_d     = norm_players(num_players_i);
        end
        ST_SELECT: if (pick_valid_i) begin
          tile_d  = pick_idx_i;
          state_d = ST_REVEAL;
        end
        ST_REVEAL: if (tc_done) state_d = ST_CHECK;
        ST_CHECK: begin
          if (match_i) begin
            state_d = ST_MOVE;
          end else begin
            player_d = next_player(player_q, np_q);
            turn_d   = (turn_q == 8'hFF) ? turn_q : turn_q + 8'd1;
            state_d  = ST_SELECT;
          end
        end
        ST_MOVE: if (move_done_i) state_d = at_goal_i ? ST_WIN : ST_SELECT;
        ST_WIN:  if (tc_done) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    tc_clr = (state_d != state_q) && ((state_d == ST_REVEAL) || (state_d == ST_WIN));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      player_q   <= 2'd0;
      np_q       <= 2'd2;
      tile_q     <= '0;
      turn_q     <= 8'd0;
      move_req_q <= 1'b0;
      win_q      <= 1'b0;
      entry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      player_q   <= player_d;
      np_q       <= np_d;
      tile_q     <= tile_d;
      turn_q     <= turn_d;
      move_req_q <= (state_d == ST_MOVE) && (state_q != ST_MOVE);
      win_q      <= (state_d == ST_WIN);
      entry_q    <= (state_d != state_q);
    end
  end

  assign mode_o     = state_q;
  assign player_o   = player_q;
  assign tile_sel_o = tile_q;
  assign move_req_o = move_req_q;
  assign win_o      = win_q;
  assign turn_cnt_o = turn_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: directed game scenarios then random play, all
// compared each cycle against a phase/age based reference model.
module tb_turn_sequencer;

  localparam int NT = 4;
  localparam int RT = 3;
  localparam int WT = 8;

  logic          clk = 1'b0;
  logic          rst, tick, start, abort, pick_valid, match, move_done, at_goal;
  logic [1:0]    num_players;
  logic [NT-1:0] pick_idx;
  logic [2:0]    mode;
  logic [1:0]    player;
  logic [NT-1:0] tile_sel;
  logic          move_req, win;
  logic [7:0]    turn_cnt;

  always #5 clk = ~clk;

  turn_sequencer #(.N_TILE_BITS(NT), .REVEAL_TICKS(RT), .WIN_TICKS(WT)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tick_i        (tick),
    .start_i       (start),
    .abort_i       (abort),
    .num_players_i (num_players),
    .pick_valid_i  (pick_valid),
    .pick_idx_i    (pick_idx),
    .match_i       (match),
    .move_done_i   (move_done),
    .at_goal_i     (at_goal),
    .mode_o        (mode),
    .player_o      (player),
    .tile_sel_o    (tile_sel),
    .move_req_o    (move_req),
    .win_o         (win),
    .turn_cnt_o    (turn_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: phase number, cycles spent in the phase, ticks counted in it
  int m_mode, m_player, m_tile, m_turn, m_np, m_age, m_ticks, m_move_req, m_win;

  function void model_reset();
    m_mode = 0; m_player = 0; m_tile = 0; m_turn = 0; m_np = 2;
    m_age = 0; m_ticks = 0; m_move_req = 0; m_win = 0;
  endfunction

  function void model_step();
    int nm;
    bit counted;
    if (rst) begin
      model_reset();
      return;
    end
    nm = m_mode;
    counted = tick && (m_age > 0);
    if (abort) nm = 0;
    else begin
      case (m_mode)
        0: if (start) begin
             nm = 1; m_player = 0; m_turn = 0;
             m_np = (num_players < 2) ? 2 : int'(num_players);
           end
        1: if (pick_valid) begin m_tile = int'(pick_idx); nm = 2; end
        2: if (counted) begin
             if (m_ticks + 1 >= RT) nm = 4; else m_ticks++;
           end
        4: if (match) nm = 3;
           else begin
             m_player = (m_player + 1) % m_np;
             if (m_turn < 255) m_turn++;
             nm = 1;
           end
        3: if (move_done) nm = at_goal ? 5 : 1;
        5: if (counted) begin
             if (m_ticks + 1 >= WT) nm = 0; else m_ticks++;
           end
        default: nm = 0;
      endcase
    end
    m_move_req = (nm == 3 && m_mode != 3) ? 1 : 0;
    m_win      = (nm == 5) ? 1 : 0;
    if (nm != m_mode) begin m_age = 0; m_ticks = 0; end
    else if (m_age < 1000) m_age++;
    m_mode = nm;
  endfunction

  task automatic compare_all();
    check("mode",     int'(mode),     m_mode);
    check("player",   int'(player),   m_player);
    check("tile_sel", int'(tile_sel), m_tile);
    check("move_req", int'(move_req), m_move_req);
    check("win",      int'(win),      m_win);
    check("turn_cnt", int'(turn_cnt), m_turn);
  endtask

  task automatic clear_inputs();
    tick = 0; start = 0; abort = 0; pick_valid = 0; pick_idx = '0;
    match = 0; move_done = 0; at_goal = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic pulse_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 0; cycle();
      tick = 1; cycle();
      tick = 0;
    end
  endtask

  // From SELECT: pick a tile, sit out REVEAL, answer CHECK with m
  task automatic do_turn(input logic [NT-1:0] idx, input logic m);
    pick_valid = 1; pick_idx = idx; cycle();
    pick_valid = 0;
    pulse_ticks(RT);
    match = m; cycle();
    match = 0;
  endtask

  initial begin
    clear_inputs();
    num_players = 2'd3;
    rst = 1;
    model_reset();
    #1;
    compare_all();
    cycle();
    rst = 0;
    cycle();
    check("idle_mode", int'(mode), 0);

    start = 1; cycle(); start = 0;
    check("start_mode", int'(mode), 1);
    check("start_player", int'(player), 0);

    pick_valid = 1; pick_idx = 4'd9; cycle(); pick_valid = 0;
    check("reveal_mode", int'(mode), 2);
    check("tile_9", int'(tile_sel), 9);
    tick = 1; cycle(); tick = 0;
    pulse_ticks(RT - 1);
    check("reveal_hold", int'(mode), 2);
    pulse_ticks(1);
    check("check_mode", int'(mode), 4);
    cycle();
    check("check_one_cycle", int'(mode), 1);
    check("p_after1", int'(player), 1);

    do_turn(4'd2, 1'b0);
    check("p_after2", int'(player), 2);
    do_turn(4'd5, 1'b0);
    check("p_wrap", int'(player), 0);
    check("turn3", int'(turn_cnt), 3);

    do_turn(4'd7, 1'b1);
    check("move_req_hi", int'(move_req), 1);
    cycle();
    check("move_req_lo", int'(move_req), 0);
    move_done = 1; at_goal = 1; cycle(); move_done = 0; at_goal = 0;
    check("win_hi", int'(win), 1);
    check("win_mode", int'(mode), 5);
    pulse_ticks(WT - 1);
    check("win_hold", int'(mode), 5);
    pulse_ticks(1);
    check("win_exit", int'(mode), 0);

    start = 1; cycle(); start = 0;
    pick_valid = 1; pick_idx = 4'd1; cycle(); pick_valid = 0;
    pulse_ticks(2);
    abort = 1; start = 1; cycle(); abort = 0; start = 0;
    check("abort_idle", int'(mode), 0);
    start = 1; cycle(); start = 0;
    pick_valid = 1; pick_idx = 4'd4; cycle(); pick_valid = 0;
    pulse_ticks(2);
    check("restart_reveal", int'(mode), 2);
    pulse_ticks(1);
    check("restart_check", int'(mode), 4);
    match = 1; cycle(); match = 0;
    move_done = 1; at_goal = 0; cycle(); move_done = 0;
    check("move_same_player", int'(mode), 1);

    do_turn(4'd8, 1'b1);
    cycle();
    #2 rst = 1;
    #1;
    model_reset();
    compare_all();
    check("async_mode", int'(mode), 0);
    cycle();
    rst = 0;
    cycle();
    check("post_rst_idle", int'(mode), 0);

    num_players = 2'd0;
    start = 1; cycle(); start = 0;
    for (int t = 0; t < 257; t++) do_turn(4'(t), 1'b0);
    check("turn_sat", int'(turn_cnt), 255);
    abort = 1; cycle(); abort = 0;

    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom % 600 == 0);
      tick        = ($urandom % 2 == 0);
      start       = ($urandom % 4 == 0);
      abort       = ($urandom % 60 == 0);
      pick_valid  = ($urandom % 3 == 0);
      pick_idx    = NT'($urandom);
      match       = ($urandom % 2 == 0);
      move_done   = ($urandom % 3 == 0);
      at_goal     = ($urandom % 3 == 0);
      num_players = 2'($urandom);
      cycle();
    end
    rst = 0;
    clear_inputs();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 Parameter: N_TILE_BITS, default 4, tile index width.
REQ-002 Parameter: REVEAL_TICKS, default 3, ticks spent in REVEAL.
REQ-003 Parameter: WIN_TICKS, default 8, ticks spent in WIN.
REQ-004 Ports: clk  in  1  single system clock, all logic on rising edge.
REQ-005 Ports: rst  in  1  asynchronous, active-high reset.
REQ-006 Ports: tick  in  1  one-cycle strobe from the tick generator, active only while mode is 000, 010 or 101.
REQ-007 Ports: start  in  1  level, begins a game from IDLE.
REQ-008 Ports: abort  in  1  level, returns to IDLE from any state.
REQ-009 Ports: num_players  in  2  player count; 0 and 1 are treated as 2; 2 means 2, 3 means 3.
REQ-010 Ports: pick_valid  in  1  one-cycle strobe, tile chosen; pick_idx  in  N_TILE_BITS  chosen tile.
REQ-011 Ports: match  in  1  datapath compare result, valid in CHECK.
REQ-012 Ports: move_done  in  1  strobe from the mover; at_goal  in  1  valid with move_done.
REQ-013 Ports: mode  out  3  current phase code, drives the tick generator and display.
REQ-014 Ports: player  out  2  active player; tile_sel  out  N_TILE_BITS  latched pick.
REQ-015 Ports: move_req  out  1  one-cycle strobe; win  out  1  level, high in WIN; turn_cnt  out  8  completed turns.

Function
REQ-016 States and mode codes: IDLE=000, SELECT=001, REVEAL=010, MOVE=011, CHECK=100, WIN=101; mode equals the state code, registered.
REQ-017 IDLE: start=1 -> SELECT; player<=0, turn_cnt<=0; num_players latched into an internal register at this transition.
REQ-018 SELECT: pick_valid=1 -> tile_sel<=pick_idx, -> REVEAL; no timeout.
REQ-019 REVEAL: 4-bit tick counter cleared on entry; a tick arriving on the entry cycle is not counted; leave to CHECK on the cycle after the REVEAL_TICKS-th counted tick.
REQ-020 CHECK lasts exactly one cycle: match=1 -> MOVE; match=0 -> player advances, turn_cnt+1, -> SELECT.
REQ-021 MOVE: move_req high for exactly the entry cycle; wait for move_done; at_goal=1 -> WIN; at_goal=0 -> SELECT with the same player.
REQ-022 WIN: win=1; counts WIN_TICKS ticks under the REVEAL_TICKS counting rule, then -> IDLE; player held for display.
REQ-023 Player advance wraps: player == latched count - 1 -> 0, else +1.
REQ-024 turn_cnt saturates at 255 and does not wrap.
REQ-025 abort=1 forces IDLE on the next edge from any state and overrides every other input; move_req and win are 0 in the following cycle.
REQ-026 start held high in IDLE after WIN restarts the game; start outside IDLE is ignored.
REQ-027 pick_valid outside SELECT, and move_done outside MOVE, are ignored; move_done on the same cycle as MOVE entry is accepted.
REQ-028 tick outside REVEAL and WIN has no effect.

Reset
REQ-029 rst=1 asynchronously forces: state IDLE, mode=000, player=0, tile_sel=0, move_req=0, win=0, turn_cnt=0, tick counter=0, latched count=2.
REQ-030 Reset asserted mid-game discards the game; after release the block waits in IDLE for start.

Structure
REQ-031 Mode codes (6 localparams) and default REVEAL_TICKS/WIN_TICKS are kept in the shared game package, which the tick generator also uses.
REQ-032 One sub-module: tick_counter, which provides clear, count-on-tick and terminal-compare, and is instanced once and reused by REVEAL and WIN.

Verification
REQ-033 Reset, then start pulse -> mode 000 then 001, player=0, turn_cnt=0.
REQ-034 pick_valid with pick_idx=9, then 3 ticks -> tile_sel=9, REVEAL; exit one cycle after the 3rd tick; CHECK for 1 cycle.
REQ-035 num_players=3, match=0 three times -> player 1, 2, 0; turn_cnt=3.
REQ-036 match=1 -> one-cycle move_req; move_done with at_goal=1 -> win=1, mode 101; 8 ticks -> mode 000.
REQ-037 abort during REVEAL after 2 ticks -> IDLE; on restart, REVEAL requires a full 3 ticks.
REQ-038 rst asserted during MOVE -> all outputs return to reset values with no clock edge.
